// File: rtl/lcd_bus_monitor_if.sv
// LCD write bus seen by the display mirror.
// RS/E/DATA as driven by the display driver.
interface lcd_bus_monitor_if;
  logic       rs;
  logic       e;
  logic [7:0] data;

  modport master (output rs, e, data);
  modport slave  (input  rs, e, data);
endinterface

// File: rtl/lcd_bus_monitor.sv
// Receive-side LCD bus monitor.
// Rebuilds a 2x16 HD44780-style screen.
module lcd_bus_monitor #(
  parameter int CLR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  lcd_bus_monitor_if.slave    bus,
  output logic [127:0]        lcd_h0,
  output logic [127:0]        lcd_h1,
  output logic                display_on,
  output logic                cfg_ok,
  output logic                busy,
  output logic                wr_strobe,
  output logic                ovr_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        rs_s1_q, rs_s2_q, rs_s3_q;
  logic        e_s1_q, e_s2_q, e_s3_q;
  logic [7:0]  data_s1_q, data_s2_q, data_s3_q;

  logic [7:0]  cell_q [32];
  logic [7:0]  cell_d [32];
  logic [6:0]  addr_q, addr_d;
  logic        id_q, id_d;
  logic        disp_q, disp_d;
  logic        cfg_q, cfg_d;
  logic        wr_q, wr_d;
  logic        ovr_q, ovr_d;

  logic        strobe;
  logic        clr_go;
  logic        clr_done;
  logic        in_win;
  logic [4:0]  widx;
  logic [7:0]  d;

  assign strobe   = ~e_s2_q & e_s3_q;
  assign d        = data_s3_q;
  assign clr_go   = strobe && (state_q == IDLE)
                    && !rs_s3_q && (d == 8'h01);
  assign clr_done = (state_q == CLEAR)
                    && (cnt_q == 5'(CLR_LEN - 1));
  assign in_win   = (addr_q[5:4] == 2'b00);
  assign widx     = {addr_q[6], addr_q[3:0]};

  // three-stage synchroniser on the whole bus
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rs_s3_q   <= 1'b0;
      e_s1_q    <= 1'b0;
      e_s2_q    <= 1'b0;
      e_s3_q    <= 1'b0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      data_s3_q <= '0;
    end else begin
      rs_s1_q   <= bus.rs;
      rs_s2_q   <= rs_s1_q;
      rs_s3_q   <= rs_s2_q;
      e_s1_q    <= bus.e;
      e_s2_q    <= e_s1_q;
      e_s3_q    <= e_s2_q;
      data_s1_q <= bus.data;
      data_s2_q <= data_s1_q;
      data_s3_q <= data_s2_q;
    end
  end

  // FSM state register and clear cell counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: clear walks all 32 cells
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_go) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 5'd1;
        if (clr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == CLEAR);
  end

  // datapath next state: decode and screen update
  always_comb begin
    cell_d = cell_q;
    addr_d = addr_q;
    id_d   = id_q;
    disp_d = disp_q;
    cfg_d  = cfg_q;
    ovr_d  = ovr_q;
    wr_d   = strobe;
    if (state_q == CLEAR) begin
      cell_d[cnt_q] = 8'h20;
      if (strobe) ovr_d = 1'b1;
      if (clr_done) begin
        addr_d = '0;
        id_d   = 1'b1;
      end
    end else if (strobe) begin
      if (rs_s3_q) begin
        if (in_win) cell_d[widx] = d;
        addr_d = id_q ? addr_q + 7'd1 : addr_q - 7'd1;
      end else begin
        unique case (1'b1)
          d[7]:                 addr_d = d[6:0];
          d[7:6] == 2'b01:      ;
          d[7:5] == 3'b001:     if (d == 8'h38) cfg_d = 1'b1;
          d[7:4] == 4'b0001:    ;
          d[7:3] == 5'b00001:   disp_d = d[2];
          d[7:2] == 6'b000001:  id_d = d[1];
          d[7:1] == 7'b0000001: addr_d = '0;
          default:              ;
        endcase
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
      addr_q <= '0;
      id_q   <= 1'b1;
      disp_q <= 1'b0;
      cfg_q  <= 1'b0;
      wr_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cell_q <= cell_d;
      addr_q <= addr_d;
      id_q   <= id_d;
      disp_q <= disp_d;
      cfg_q  <= cfg_d;
      wr_q   <= wr_d;
      ovr_q  <= ovr_d;
    end
  end

  // pack cells into line images, column 0 in the top byte
  always_comb begin
    lcd_h0 = '0;
    lcd_h1 = '0;
    for (int i = 0; i < 16; i++) begin
      lcd_h0[127-8*i -: 8] = cell_q[i];
      lcd_h1[127-8*i -: 8] = cell_q[16+i];
    end
  end

  assign display_on = disp_q;
  assign cfg_ok     = cfg_q;
  assign wr_strobe  = wr_q;
  assign ovr_err    = ovr_q;

endmodule
